// File: rtl/hack_mem_pkg.sv
// hack_mem_pkg: shared scanner state type and default RAM geometry for ram_scan_dp
package hack_mem_pkg;
  typedef enum logic {IDLE, RUN} scan_state_t;
  localparam int REG_W_DEF = 16;
  localparam int ADD_W_DEF = 14;
endpackage

// File: rtl/ram_scan_ctrl.sv
// ram_scan_ctrl: streaming-port FSM that walks scan_ptr over a RAM region with valid/ready
// Ports: clk, reset (async, active-high), busy (blocks new requests),
//        scan_start/scan_base/scan_len (request), scan_ready (consumer accept),
//        scan_ptr (current word address), scan_valid, scan_done (one-cycle pulse).
module ram_scan_ctrl
  import hack_mem_pkg::*;
#(
  parameter int ADD_W = ADD_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             busy,
  input  logic             scan_start,
  input  logic [ADD_W-1:0] scan_base,
  input  logic [ADD_W:0]   scan_len,
  input  logic             scan_ready,
  output logic [ADD_W-1:0] scan_ptr,
  output logic             scan_valid,
  output logic             scan_done
);
  scan_state_t state, state_nx;
  logic [ADD_W:0] remaining, rem_nx;
  logic [ADD_W-1:0] ptr_nx;
  logic done_nx;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      scan_ptr  <= '0;
      remaining <= '0;
      scan_done <= 1'b0;
    end else begin
      state     <= state_nx;
      scan_ptr  <= ptr_nx;
      remaining <= rem_nx;
      scan_done <= done_nx;
    end
  always_comb begin
    state_nx = state;
    ptr_nx   = scan_ptr;
    rem_nx   = remaining;
    done_nx  = 1'b0;
    if (state == IDLE) begin
      if (scan_start && !busy) begin
        ptr_nx   = scan_base;
        rem_nx   = scan_len;
        state_nx = (scan_len == '0) ? IDLE : RUN;
        done_nx  = (scan_len == '0);
      end
    end else if (scan_ready) begin
      // pointer width equals the address width, so the increment wraps modulo DEPTH
      ptr_nx = scan_ptr + 1'b1;
      rem_nx = remaining - 1'b1;
      if (remaining == (ADD_W+1)'(1)) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
    end
  end
  assign scan_valid = (state == RUN);
endmodule

// File: rtl/ram_scan_dp.sv
// ram_scan_dp: Hack RAM with single-cycle CPU port, read-only valid/ready stream port and optional clear sweep
// Ports: clk, reset (async, active-high); CPU port in/load/address/out;
//        busy (clear sweep running); stream port scan_start/scan_base/scan_len,
//        scan_valid/scan_ready/scan_data, scan_done.
// Macro RAM_SCAN_CLEAR_EN: when defined, every reset release zeroes the whole
// memory (DEPTH cycles, busy high); otherwise busy is tied low and contents start undefined.
module ram_scan_dp
  import hack_mem_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int ADD_W = ADD_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] in,
  input  logic             load,
  input  logic [ADD_W-1:0] address,
  output logic [REG_W-1:0] out,
  output logic             busy,
  input  logic             scan_start,
  input  logic [ADD_W-1:0] scan_base,
  input  logic [ADD_W:0]   scan_len,
  output logic             scan_valid,
  input  logic             scan_ready,
  output logic [REG_W-1:0] scan_data,
  output logic             scan_done
);
  logic [REG_W-1:0] mem [0:(1<<ADD_W)-1];
  logic [ADD_W-1:0] scan_ptr;
`ifdef RAM_SCAN_CLEAR_EN
  // clr_cnt runs 0..DEPTH; its top bit marks the sweep as finished
  logic [ADD_W:0] clr_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) clr_cnt <= '0;
    else if (busy) clr_cnt <= clr_cnt + 1'b1;
  assign busy = ~clr_cnt[ADD_W];
  always_ff @(posedge clk)
    if (busy) mem[clr_cnt[ADD_W-1:0]] <= '0;
    else if (load) mem[address] <= in;
`else
  assign busy = 1'b0;
  always_ff @(posedge clk)
    if (load) mem[address] <= in;
`endif
  assign out       = busy ? '0 : mem[address];
  assign scan_data = mem[scan_ptr];
  ram_scan_ctrl #(.ADD_W(ADD_W)) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .busy       (busy),
    .scan_start (scan_start),
    .scan_base  (scan_base),
    .scan_len   (scan_len),
    .scan_ready (scan_ready),
    .scan_ptr   (scan_ptr),
    .scan_valid (scan_valid),
    .scan_done  (scan_done)
  );
endmodule

// File: doc/ram_scan_dp.md
# ram_scan_dp

Parametrised successor to the Hack RAM. It keeps the CPU port unchanged: combinational read, and a write on the clock edge when `load` is high. It adds a read-only streaming port with a valid/ready handshake and a hardware clear sweep after reset. It sits between the CPU data bus and the screen/DMA logic, so a display refresh can stream a region of RAM while the CPU keeps its single-cycle access.

## Interface
- `REG_W`, default 16: word width in bits.
- `ADD_W`, default 14: address width; DEPTH = 2**ADD_W words.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in` in REG_W: CPU write data.
- `load` in 1: CPU write enable.
- `address` in ADD_W: CPU address.
- `out` out REG_W: CPU read data, mem[address], combinational.
- `busy` out 1: clear sweep in progress.
- `scan_start` in 1: one-cycle request to start a stream.
- `scan_base` in ADD_W: first stream address, sampled with `scan_start`.
- `scan_len` in ADD_W+1: word count, 0..DEPTH, sampled with `scan_start`.
- `scan_valid` out 1: `scan_data` is valid.
- `scan_ready` in 1: consumer accepts the current word.
- `scan_data` out REG_W: mem[scan_ptr], combinational.
- `scan_done` out 1: one-cycle pulse after the final word, or after a zero-length request.

## Operation
- **CPU port**
  - Write mem[address] <= in on the rising edge when `load` is high and `busy` is low.
  - `out` follows `address` combinationally.
  - A same-cycle read returns the old value; the new value appears after the edge.
  - `out` is forced to 0 while `busy` is high.
- **Scanner FSM**
  - States: IDLE, RUN.
  - IDLE: when `scan_start` is high and `busy` is low, latch scan_ptr = scan_base and remaining = scan_len.
    - If scan_len != 0, go to RUN.
    - If scan_len = 0, stay in IDLE and pulse `scan_done`.
  - RUN: `scan_valid` is 1. On every edge with `scan_ready` high:
    - scan_ptr increments modulo DEPTH (0x3FFF wraps to 0x0000).
    - remaining decrements.
    - If remaining was 1, go to IDLE and pulse `scan_done` for the next cycle.
  - `scan_ready` low: `scan_valid` stays high, scan_ptr holds, and `scan_data` stays stable unless the CPU writes that word.
  - `scan_start` is ignored in RUN and while `busy` is high.
  - CPU write to mem[scan_ptr]:
    - `scan_data` shows the new value after the edge.
    - A handshake on the same edge delivers the old value.
- **Clear sweep** (macro only)
  - Starts when `reset` deasserts.
  - Writes 0 to addresses 0..DEPTH-1, one word per cycle, with `busy` = 1.
  - `busy` falls after exactly DEPTH cycles.
- **Reset mid-operation**
  - `reset` asynchronously forces: scanner to IDLE, `scan_valid` = 0, `scan_done` = 0, clear pointer to 0, `busy` = 1 (macro).
  - The sweep restarts from address 0.

## Timing
- **Reset values:** `scan_valid` 0; `scan_done` 0; `busy` 1 (macro) or 0 (no macro); `out` 0 (macro) or mem[address] (no macro).
- **Latencies:**
  - CPU write to read visibility: 1 edge.
  - `scan_start` to `scan_valid`: 1 cycle.
  - Final handshake to `scan_done`: 1 cycle.
- **Throughput:** 1 word per cycle with `scan_ready` held high. A stream of N words occupies N cycles in RUN.
- **Clear sweep duration:** DEPTH cycles (16384 at the default).

## Configuration
- `RAM_SCAN_CLEAR_EN` defined:
  - The clear FSM and `busy` logic are compiled in.
  - Memory reads 0 everywhere after the sweep.
- Not defined:
  - `busy` is tied to 0, and writes and scans are accepted from the first edge after reset.
  - Memory contents after reset are undefined (X in simulation).

## Structure
- Package `hack_mem_pkg`:
  - `scan_state_t` enum {IDLE, RUN}.
  - Default constants REG_W_DEF = 16 and ADD_W_DEF = 14.
- Sub-module `ram_scan_ctrl`: scanner FSM, scan_ptr and remaining counters, and `scan_done`.
- Top level holds the memory array, the CPU port and the clear FSM.

## Test plan
- **Clear sweep and write blocking:** release reset → `busy` = 1 for exactly 16384 cycles. `load` = 1, address 0x0005, in 0x1234 during `busy` → no write; after `busy` falls, `out` at 0x0005 = 0x0000.
- **CPU write:** load = 1, address 0x0010, in 0xBEEF → `out` = 0x0000 before the edge and 0xBEEF after it.
- **Wrap-around stream:** preload 0x3FFE = 0x1111, 0x3FFF = 0x2222, 0x0000 = 0x3333, 0x0001 = 0x4444. Start base 0x3FFE, len 4, `scan_ready` = 1 → `scan_data` 0x1111, 0x2222, 0x3333, 0x4444 on 4 consecutive cycles; `scan_done` high for one cycle after the last word.
- **Backpressure:** same stream with `scan_ready` low for 3 cycles after the second word → `scan_valid` held and `scan_data` stays 0x2222; sequence resumes intact.
- **Zero length and ignored start:** scan_len = 0 → `scan_done` pulse 1 cycle later with `scan_valid` never high. A second `scan_start` during RUN → ignored; word count unchanged.
- **Reset mid-scan:** assert `reset` mid-scan → `scan_valid` drops without waiting for a clock edge and `busy` rises. After release, clear restarts at 0x0000 and lasts 16384 cycles.
